minimips_sequencer: RTL and testbench
=====================================

// Module: minimips_sequencer
// PURPOSE
//  Multi-cycle sequencer for the MiniMIPS datapath. Owns the PC and fetches 16-bit words from instruction memory.
//  Holds each word on instr[15:0] into the datapath; fields are opcode[15:12] rs[11:9] rt[8:6] rd[5:3] func[2:0] imm[5:0].
//  Issues one-cycle register-file and data-memory strobes. Resolves BEQ/BNE from the ALU zero flag.
//  Sits between instruction memory and the MiniMIPS datapath; replaces the datapath's free-running clk/write assumption.
// PARAMETERS
//  PC_W      8    PC width; word-addressed, one instruction per word
//  RESET_PC  0    PC value loaded on reset and on start
//  MAX_WAIT  15   cycles FETCH may wait for imem_ack before ERROR
// PORTS
//  clk           in   1     single clock, rising edge
//  reset         in   1     synchronous, active-high
//  start         in   1     pulse; leaves IDLE/HALTED, PC<=RESET_PC
//  halt_req      in   1     level; stop at next instruction boundary
//  imem_req      out  1     fetch request, held until imem_ack
//  imem_addr     out  PC_W  fetch address (= pc)
//  imem_ack      in   1     rdata valid this cycle
//  imem_rdata    in   16    fetched instruction
//  instr         out  16    latched IR driven to datapath
//  alu_zero      in   1     datapath ALU result == 0
//  reg_write_en  out  1     one-cycle register-file write strobe
//  mem_read_en   out  1     data-memory read enable (MEM state)
//  mem_write_en  out  1     one-cycle data-memory write strobe
//  pc            out  PC_W  current PC
//  busy          out  1     1 in FETCH..WB
//  halted        out  1     1 in HALTED
//  err           out  1     sticky fetch timeout
//  instr_count   out  32    retired instructions, wraps 2^32
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, pc=RESET_PC, instr=0, instr_count=0.
//   - All strobes, busy, halted and err are 0.
//  Opcode classes: R=4'h0; LW=4'h8; SW=4'h9; BEQ=4'h5; BNE=4'h6; HALT=4'hF; all others are I-type ALU.
//  IDLE: start -> FETCH.
//  FETCH:
//   - imem_req=1; imem_ack in the same cycle is accepted.
//   - On ack: instr<=imem_rdata, wait counter cleared, -> DECODE.
//   - After MAX_WAIT cycles with no ack: -> ERROR.
//  DECODE: 1 cycle (datapath settles). HALT opcode -> HALTED; instr_count does not increment.
//  EXEC: 1 cycle. Next state and PC update by class:
//   - R/I-type -> WB.
//   - LW/SW -> MEM.
//   - BEQ: taken iff alu_zero=1. BNE: taken iff alu_zero=0.
//   - Taken branch: pc<=pc+1+sext(imm[5:0]). Not taken: pc<=pc+1. Then retire.
//  MEM:
//   - mem_read_en=1 for LW -> WB.
//   - mem_write_en=1 for SW; pc<=pc+1; retire.
//  WB: reg_write_en=1 for exactly this cycle; pc<=pc+1; retire.
//  Retire:
//   - instr_count+=1.
//   - halt_req=1 -> HALTED, else -> FETCH.
//  Cycles per instruction (ack in 1st FETCH cycle): R/I=4, LW=5, SW=4, branch=3.
//  PC arithmetic: modulo 2^PC_W, so 0xFF+1 -> 0x00; negative offset wraps the same way.
//  halt_req asserted mid-instruction: the current instruction completes, including its strobes.
//  HALTED: start -> FETCH at RESET_PC; instr_count is kept.
//  ERROR:
//   - err=1, no strobes; only reset exits.
//   - start is ignored.
//  start while busy: ignored.
//  reset mid-instruction: strobes drop in the same edge; no partial write is issued afterward.
// STRUCTURE
//  minimips_defs.vh (shared, included by datapath control and this block):
//   - opcode localparams and field bit positions.
//   - state encodings IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR (3-bit).
//  Sub-module minimips_pc_unit: PC register, +1 incrementer, sign-extend/branch adder, load/reset mux.
//  FSM, IR, wait counter and instr_count stay in minimips_sequencer.
// TESTING
//  1. Reset, start, ack every cycle; ADD 0x0..: 4 cycles; reg_write_en high 1 cycle in WB; pc 0->1; instr_count=1.
//  2. BEQ imm=6'h3E (-2) at pc=5, alu_zero=1 -> pc=4; same with BNE -> pc=6; no write strobes.
//  3. LW then SW: mem_read_en only in LW MEM cycle; mem_write_en 1 cycle in SW; reg_write_en only for LW.
//  4. imem_ack withheld 16 cycles (MAX_WAIT=15) -> err=1, busy=0, strobes 0; start ignored; reset clears err.
//  5. halt_req raised in EXEC of ADD -> WB write still occurs, then halted=1, pc=1; start -> pc=0, FETCH.
//  6. pc=0xFF, ADD -> pc=0x00. Reset asserted during WB -> no reg_write_en the next cycle; state IDLE.

Source files
------------

// File: rtl/minimips_pkg.sv
// Shared MiniMIPS definitions: opcode classes, instruction field positions
// and the sequencer state encoding used by control and the sequencer.
package minimips_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int FN_MSB  = 2;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // Only meaningful for BEQ/BNE opcodes.
    function automatic logic branch_taken(input logic [3:0] op, input logic zero);
        return (op == OP_BEQ) ? zero : !zero;
    endfunction

endpackage

// File: rtl/minimips_pc_unit.sv
// Program counter: register, +1 incrementer, sign-extended branch adder and
// load/reset selection. Arithmetic wraps modulo 2^PC_W.
module minimips_pc_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic            branch_i,
    input  logic [5:0]      imm_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] imm_sext;

    assign imm_sext = {{(PC_W-6){imm_i[5]}}, imm_i};
    assign pc_inc   = pc_q + PC_W'(1);
    // Branch target is relative to the already-incremented PC.
    assign pc_br    = pc_inc + imm_sext;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = RESET_PC;
        end else if (branch_i) begin
            pc_d = pc_br;
        end else if (inc_i) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/minimips_sequencer.sv
// Multi-cycle MiniMIPS sequencer: fetches into the IR, steps DECODE/EXEC/MEM/WB
// and issues one-cycle register-file and data-memory strobes.
module minimips_sequencer
    import minimips_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    input  logic            alu_zero,
    output logic            reg_write_en,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [31:0]     instr_count,
    output logic [2:0]      dbg_state
);

    localparam int              WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       count_q, count_d;
    logic              pc_load, pc_inc, pc_branch, retire;
    logic [3:0]        opcode;
    logic              taken;

    assign opcode = instr_q[OPC_MSB:OPC_LSB];
    assign taken  = branch_taken(opcode, alu_zero);

    minimips_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i    (clk),
        .reset_i  (reset),
        .load_i   (pc_load),
        .inc_i    (pc_inc),
        .branch_i (pc_branch),
        .imm_i    (instr_q[IMM_MSB:IMM_LSB]),
        .pc_o     (pc)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        wait_d    = wait_q;
        count_d   = count_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_load = 1'b1;
                    wait_d  = '0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = WAIT_W'(wait_q + 1'b1);
                end
            end
            ST_DECODE: begin
                state_d = (opcode == OP_HALT) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM;
                    OP_BEQ, OP_BNE: begin
                        pc_branch = taken;
                        pc_inc    = !taken;
                        retire    = 1'b1;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (opcode == OP_LW) begin
                    state_d = ST_WB;
                end else begin
                    pc_inc = 1'b1;
                    retire = 1'b1;
                end
            end
            ST_WB: begin
                pc_inc = 1'b1;
                retire = 1'b1;
            end
            default: state_d = ST_ERROR;
        endcase
        // Instruction boundary: the only place halt_req is honoured.
        if (retire) begin
            count_d = count_q + 32'd1;
            state_d = halt_req ? ST_HALTED : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Strobes decode the registered state only, so reset removes them on the same edge.
    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc;
    assign instr        = instr_q;
    assign reg_write_en = (state_q == ST_WB);
    assign mem_read_en  = (state_q == ST_MEM) && (opcode == OP_LW);
    assign mem_write_en = (state_q == ST_MEM) && (opcode == OP_SW);
    assign busy         = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                          (state_q == ST_EXEC)  || (state_q == ST_MEM)    ||
                          (state_q == ST_WB);
    assign halted       = (state_q == ST_HALTED);
    assign err          = (state_q == ST_ERROR);
    assign instr_count  = count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_minimips_sequencer.sv
// Directed bench for minimips_sequencer: a small instruction memory, a per-
// instruction scoreboard of final PC, strobe counts and cycle count.
module tb_minimips_sequencer;
    import minimips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr;
    logic        alu_zero = 1'b0;
    logic        reg_write_en, mem_read_en, mem_write_en;
    logic [7:0]  pc;
    logic        busy, halted, err;
    logic [31:0] instr_count;
    logic [2:0]  dbg_state;

    minimips_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .alu_zero(alu_zero),
        .reg_write_en(reg_write_en), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .pc(pc), .busy(busy), .halted(halted),
        .err(err), .instr_count(instr_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] I_ADD  = 16'h0290;
    localparam logic [15:0] I_ADDI = 16'h1245;
    localparam logic [15:0] I_LW   = 16'h8281;
    localparam logic [15:0] I_SW   = 16'h9281;
    localparam logic [15:0] I_BEQ  = 16'h52BE;  // imm = -2
    localparam logic [15:0] I_BNE  = 16'h62BE;  // imm = -2
    localparam logic [15:0] I_HALT = 16'hF000;

    logic [15:0] mem [0:255];
    logic        ack_en = 1'b1;
    int          checks = 0;
    int          failures = 0;

    // {pc after retire, reg writes, mem reads, mem writes, busy cycles}
    logic [17:0] exp_q[$];
    logic [1:0]  rw_cnt, mr_cnt, mw_cnt;
    logic [3:0]  cyc_cnt;
    logic [31:0] prev_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] ins, input logic [7:0] p, input logic z);
        logic [7:0] nxt;
        logic [7:0] tgt;
        nxt = p + 8'd1;
        tgt = nxt + {{2{ins[5]}}, ins[5:0]};
        case (ins[15:12])
            4'h8:    return {nxt, 2'd1, 2'd1, 2'd0, 4'd5};
            4'h9:    return {nxt, 2'd0, 2'd0, 2'd1, 4'd4};
            4'h5:    return {(z ? tgt : nxt), 2'd0, 2'd0, 2'd0, 4'd3};
            4'h6:    return {(!z ? tgt : nxt), 2'd0, 2'd0, 2'd0, 4'd3};
            default: return {nxt, 2'd1, 2'd0, 2'd0, 4'd4};
        endcase
    endfunction

    task automatic clear_track();
        rw_cnt = '0; mr_cnt = '0; mw_cnt = '0; cyc_cnt = '0;
    endtask

    // One clock: drive memory response, observe current cycle, step, score retirement.
    task automatic tick();
        logic [17:0] e;
        imem_ack   = ack_en && imem_req;
        imem_rdata = mem[imem_addr];
        if (imem_ack && !reset && mem[imem_addr][15:12] != 4'hF)
            exp_q.push_back(model(mem[imem_addr], imem_addr, alu_zero));
        if (busy) cyc_cnt++;
        if (reg_write_en) rw_cnt++;
        if (mem_read_en) mr_cnt++;
        if (mem_write_en) mw_cnt++;
        prev_count = instr_count;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            clear_track();
        end else if (instr_count != prev_count) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_retire", instr_count, prev_count);
            end else begin
                e = exp_q.pop_front();
                check("sb_retire", {14'd0, pc, rw_cnt, mr_cnt, mw_cnt, cyc_cnt}, {14'd0, e});
            end
            clear_track();
        end else if (!busy) begin
            clear_track();
        end
    endtask

    task automatic wait_retire(input logic [31:0] target);
        for (int i = 0; i < 60 && instr_count != target; i++) tick();
        check("retire_wait", instr_count, target);
    endtask

    task automatic wait_state(input logic [2:0] st);
        for (int i = 0; i < 60 && dbg_state != st; i++) tick();
        check("state_wait", {29'd0, dbg_state}, {29'd0, st});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = I_ADD;
        mem[1] = I_ADDI;
        mem[2] = I_LW;
        mem[3] = I_SW;
        mem[4] = I_ADD;
        mem[5] = I_BEQ;
        mem[6] = I_HALT;
        clear_track();

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_instr", {16'd0, instr}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_flags", {26'd0, busy, halted, err, reg_write_en, mem_read_en, mem_write_en}, 32'd0);

        // ADD: FETCH, DECODE, EXEC, WB with a single write strobe.
        pulse_start();
        check("start_fetch", {29'd0, dbg_state}, {29'd0, ST_FETCH});
        tick();
        check("add_instr", {16'd0, instr}, {16'd0, I_ADD});
        tick();
        tick();
        check("add_wb_strobe", {31'd0, reg_write_en}, 32'd1);
        check("add_wb_pc", {24'd0, pc}, 32'd0);
        tick();
        check("add_after_wb", {31'd0, reg_write_en}, 32'd0);
        check("add_pc", {24'd0, pc}, 32'd1);
        check("add_count", instr_count, 32'd1);

        // ADDI, LW, SW, ADD, then BEQ -2 taken at pc=5.
        alu_zero = 1'b1;
        wait_retire(32'd6);
        check("beq_taken_pc", {24'd0, pc}, 32'd4);
        mem[5] = I_BNE;
        wait_retire(32'd8);
        check("bne_not_taken_pc", {24'd0, pc}, 32'd6);
        wait_state(ST_HALTED);
        check("halt_op_flag", {31'd0, halted}, 32'd1);
        check("halt_op_count", instr_count, 32'd8);
        check("halt_op_pc", {24'd0, pc}, 32'd6);

        // halt_req raised in EXEC: the WB write still happens, then HALTED.
        pulse_start();
        check("restart_pc", {24'd0, pc}, 32'd0);
        check("restart_state", {29'd0, dbg_state}, {29'd0, ST_FETCH});
        wait_state(ST_EXEC);
        halt_req = 1'b1;
        wait_state(ST_HALTED);
        halt_req = 1'b0;
        check("halt_req_pc", {24'd0, pc}, 32'd1);
        check("halt_req_count", instr_count, 32'd9);

        // Negative branch wraps 0 -> 0xFF, then 0xFF + 1 wraps to 0.
        mem[0] = I_BEQ;
        pulse_start();
        wait_retire(32'd10);
        check("wrap_neg_pc", {24'd0, pc}, 32'hFF);
        mem[0] = I_ADD;
        wait_retire(32'd11);
        check("wrap_pos_pc", {24'd0, pc}, 32'd0);

        // Reset during WB drops the write strobe immediately.
        wait_state(ST_WB);
        check("pre_rst_wb", {31'd0, reg_write_en}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wb_strobe", {31'd0, reg_write_en}, 32'd0);
        check("rst_wb_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_wb_count", instr_count, 32'd0);
        tick();
        check("rst_wb_no_late", {31'd0, reg_write_en}, 32'd0);

        // Fetch timeout: 14 unanswered cycles still waiting, the 15th errors out.
        ack_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 14; i++) tick();
        check("timeout_pending", {30'd0, err, busy}, 32'd1);
        tick();
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_quiet", {28'd0, busy, imem_req, reg_write_en, mem_write_en}, 32'd0);
        pulse_start();
        check("err_ignores_start", {29'd0, dbg_state}, {29'd0, ST_ERROR});
        check("err_sticky", {31'd0, err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_en = 1'b1;
        check("err_cleared", {31'd0, err}, 32'd0);
        check("err_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
